// File: rtl/uart_frame_sched.sv
// Round-robin frame scheduler: shares one UART transmitter among NCH sample channels,
// sending each accepted sample as a header / id / data / checksum frame.
module uart_frame_sched #(
   parameter int         NCH = 4,
   parameter logic [7:0] HDR = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [NCH-1:0]   ch_valid,
   input  logic [8*NCH-1:0] ch_data,
   output logic [NCH-1:0]   ch_ready,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   input  logic             tx_busy,
   output logic             frame_active,
   output logic [7:0]       frame_cnt
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, PULSE, SKIP, WAIT} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] rr_ptr, winner;
   logic          found, grant;
   logic [7:0]    id_q, data_q, sel_data, byte_nx;
   logic [1:0]    byte_idx;

   // First valid channel searching upward from rr_ptr, wrapping at NCH-1.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NCH; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
         idx = sum[PW-1:0];
         if (!found && ch_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (PW'(k) == winner) sel_data = ch_data[8*k +: 8];
      end
   end

   assign grant = (state == IDLE) && ena && !tx_busy && found && !rst;

   always_comb begin
      ch_ready = '0;
      if (grant) ch_ready[winner] = 1'b1;
   end

   always_comb begin
      byte_nx = HDR;
      case (byte_idx)
         2'd0:    byte_nx = HDR;
         2'd1:    byte_nx = id_q;
         2'd2:    byte_nx = data_q;
         default: byte_nx = id_q ^ data_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // SKIP exists because the transmitter's busy flag lags its start pulse by a cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = LOAD;
         LOAD:    state_nx = PULSE;
         PULSE:   state_nx = SKIP;
         SKIP:    state_nx = WAIT;
         WAIT:    if (!tx_busy) state_nx = (byte_idx == 2'd3) ? IDLE : LOAD;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_start     <= 1'b0;
         tx_data      <= '0;
         frame_active <= 1'b0;
         frame_cnt    <= '0;
         rr_ptr       <= '0;
         id_q         <= '0;
         data_q       <= '0;
         byte_idx     <= '0;
      end else begin
         tx_start <= (state == LOAD);
         case (state)
            IDLE: begin
               if (grant) begin
                  id_q         <= 8'(winner);
                  data_q       <= sel_data;
                  rr_ptr       <= (winner == PW'(NCH-1)) ? '0 : winner + 1'b1;
                  byte_idx     <= '0;
                  frame_active <= 1'b1;
               end
            end
            LOAD: tx_data <= byte_nx;
            WAIT: begin
               if (!tx_busy) begin
                  if (byte_idx == 2'd3) begin
                     frame_active <= 1'b0;
                     frame_cnt    <= frame_cnt + 8'd1;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
